dram_read_arbiter: RTL and testbench
====================================

# dram_read_arbiter

Two-port read arbiter that shares the single line-fill port of `dram_emulation_mem` between the instruction `direct_cache` and the data `direct_cache`. The arbiter sits between both caches' `mem_*` ports and the DRAM port, and grants one outstanding line read at a time. It latches the winner's line address and routes the returned line and its valid pulse back to that winner only. Grant policy is round-robin by default, with fixed priority as a compile option.

## Interface
Parameters:
- `ByteOffsetBits`, 4: byte offset bits of a cache line; `LineSize = 8 * 2**ByteOffsetBits`.
- `IndexBits`, 6: cache index bits; carried for consistency with the caches, unused internally.
- `TagBits`, 22: cache tag bits; carried for consistency with the caches, unused internally.

Ports:
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `rstn_i`, in, 1: reset, asynchronous and active-low.
- `ic_mem_read_en_i`, in, 1: instruction-cache line request, held as a level until served.
- `ic_mem_addr_i`, in, 32: instruction-cache miss address.
- `ic_mem_read_valid_o`, out, 1: one-cycle pulse when the instruction-cache line is returned.
- `ic_mem_read_data_o`, out, LineSize: returned line for the instruction cache.
- `dc_mem_read_en_i`, in, 1: data-cache line request, held as a level until served.
- `dc_mem_addr_i`, in, 32: data-cache miss address.
- `dc_mem_read_valid_o`, out, 1: one-cycle pulse when the data-cache line is returned.
- `dc_mem_read_data_o`, out, LineSize: returned line for the data cache.
- `mem_read_en_o`, out, 1: DRAM read enable.
- `mem_addr_o`, out, 32: DRAM line address.
- `mem_read_valid_i`, in, 1: DRAM read-valid pulse.
- `mem_read_data_i`, in, LineSize: DRAM line data.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If any request is high, pick an owner, latch the owner's address with the low `ByteOffsetBits` bits forced to 0, and go to BUSY.
  - If no request is high, stay in IDLE.
- **BUSY**
  - `mem_read_en_o`=1 and `mem_addr_o` equals the latched address, both stable.
  - Wait for `mem_read_valid_i`; on it, go to DONE.
  - There is no timeout.
- **DONE**
  - One turnaround cycle with `mem_read_en_o`=0, then go to IDLE.
  - No grant is made in DONE, so a request still asserted in the cycle after its valid is never re-granted.
- Owner choice (round-robin):
  - If only one requester is asserted, it wins.
  - If both are asserted, the requester not granted last wins.
  - `last_grant` resets to DC, so the first tie goes to IC.
- Response routing, combinational from `mem_read_valid_i`:
  - `ic_mem_read_valid_o = mem_read_valid_i & (state==BUSY) & (owner==IC)`; `dc_mem_read_valid_o` is symmetric.
  - Both `*_read_data_o` carry `mem_read_data_i` directly; the valid pulse qualifies which one is meaningful.
- `mem_read_valid_i` in IDLE or DONE is ignored and never forwarded.
- A requester dropping its request while owner in BUSY does not cancel the transaction; the line is still returned and the valid still pulses.

## Timing
- Reset values:
  - `state`=IDLE.
  - `mem_read_en_o`=0.
  - `mem_addr_o`=0.
  - `last_grant`=DC.
  - `ic_mem_read_valid_o` and `dc_mem_read_valid_o` are 0 because state is IDLE.
- Grant latency: request sampled at edge N, so `mem_read_en_o` and `mem_addr_o` are valid from edge N (registered outputs, 1 cycle after the request rises).
- Response latency: same cycle as `mem_read_valid_i`, 0 added cycles.
- Back-to-back service: minimum 2 idle cycles between the valid pulse and the next `mem_read_en_o` rise (DONE, then IDLE sampling).
- Reset mid-BUSY: the arbiter returns to reset values immediately. A late DRAM valid then arrives in IDLE and is dropped.

## Configuration
- `DRAM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration as described in Operation.
- `DRAM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, DC always wins a tie.
  - `last_grant` is not implemented.

## Structure
- Package `dram_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t`
  - `typedef enum logic {OWNER_IC, OWNER_DC} arb_owner_t`
  - the `LineSize` derivation as a function of `ByteOffsetBits`.
- Single flat module; the pick logic is small and needs no sub-module.

## Test plan
All scenarios use DRAM latency 10.
- IC alone requests `0x00000414`:
  - `mem_addr_o`=`0x00000410` and `mem_read_en_o`=1 one cycle later.
  - `ic_mem_read_valid_o` pulses exactly once, with the DRAM line on `ic_mem_read_data_o`.
  - `dc_mem_read_valid_o` stays 0.
- IC `0x00000424` and DC `0x00000818` request in the same cycle after reset:
  - With the macro: IC is served first, then DC at `0x00000810`.
  - Without the macro: DC is served first, then IC.
- IC holds its request high one cycle after its valid:
  - No second DRAM read is issued.
  - `mem_read_en_o` stays 0 for 2 cycles.
- DC requests `0x00000440`; `rstn_i` is pulsed low 4 cycles into BUSY:
  - All outputs return to 0 immediately.
  - The late DRAM valid produces no `*_read_valid_o` pulse.
- DC requests while IC is BUSY on `0x00000410`:
  - DC waits with `mem_addr_o` unchanged.
  - DC is granted right after DONE, and `mem_addr_o` becomes the DC line address.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types for the DRAM line-fill read arbiter: FSM states, owner encoding, line width.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dram_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

    typedef enum logic {OWNER_IC, OWNER_DC} arb_owner_t;

    // Cache line width in bits for a given number of byte-offset bits.
    function automatic int line_size(input int byte_offset_bits);
        return 8 * (1 << byte_offset_bits);
    endfunction

endpackage

// File: rtl/dram_read_arbiter.sv
// Shares the single DRAM line-fill port between the instruction and data caches, one read at a time.
// Latency: grant registered 1 cycle after request; returned line and valid are routed combinationally (0 cycles).
// Backpressure: losing requester holds its level request until granted; DRAM has no timeout.
// Build option: DRAM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise the data cache always wins a tie.
import dram_arb_pkg::*;

module dram_read_arbiter #(
    parameter int ByteOffsetBits = 4,
    parameter int IndexBits      = 6,
    parameter int TagBits        = 22
) (
    input  logic                                    clk_i,
    input  logic                                    rstn_i,
    input  logic                                    ic_mem_read_en_i,
    input  logic [31:0]                             ic_mem_addr_i,
    output logic                                    ic_mem_read_valid_o,
    output logic [line_size(ByteOffsetBits)-1:0]    ic_mem_read_data_o,
    input  logic                                    dc_mem_read_en_i,
    input  logic [31:0]                             dc_mem_addr_i,
    output logic                                    dc_mem_read_valid_o,
    output logic [line_size(ByteOffsetBits)-1:0]    dc_mem_read_data_o,
    output logic                                    mem_read_en_o,
    output logic [31:0]                             mem_addr_o,
    input  logic                                    mem_read_valid_i,
    input  logic [line_size(ByteOffsetBits)-1:0]    mem_read_data_i
);

    // Tag/index only describe the caches' geometry; the arbiter just needs it to fit a 32-bit address.
    if (TagBits + IndexBits + ByteOffsetBits > 32) begin : g_geometry_too_wide
        $error("cache geometry exceeds a 32-bit address");
    end

    arb_state_t  r_state;
    arb_owner_t  r_owner;
    logic [31:0] r_addr;
    logic        r_read_en;

    arb_owner_t  w_pick;
    logic [31:0] w_pick_addr;
    logic        w_any_req;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
    arb_owner_t  r_last_grant;
`endif

    assign w_any_req = ic_mem_read_en_i | dc_mem_read_en_i;

    // Choose the next owner; a lone requester always wins, ties follow the build option.
    always_comb begin
        w_pick = OWNER_IC;
        if (ic_mem_read_en_i && dc_mem_read_en_i) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
            w_pick = (r_last_grant == OWNER_DC) ? OWNER_IC : OWNER_DC;
`else
            w_pick = OWNER_DC;
`endif
        end else if (dc_mem_read_en_i) begin
            w_pick = OWNER_DC;
        end
        w_pick_addr = (w_pick == OWNER_DC) ? dc_mem_addr_i : ic_mem_addr_i;
    end

    // Main FSM: grant in IDLE, hold the read in BUSY until DRAM answers, one turnaround cycle in DONE.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= IDLE;
            r_owner   <= OWNER_IC;
            r_addr    <= '0;
            r_read_en <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_pick;
                        r_addr    <= {w_pick_addr[31:ByteOffsetBits], {ByteOffsetBits{1'b0}}};
                        r_read_en <= 1'b1;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_read_valid_i) begin
                        r_read_en <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    // No grant here, so a request still high right after its valid is not served twice.
                    r_state <= IDLE;
                end
                default: begin
                    r_read_en <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

`ifdef DRAM_ARB_ROUND_ROBIN_EN
    // Remember the last winner so the next tie goes to the other cache; starts at DC so IC wins the first tie.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last_grant <= OWNER_DC;
        end else if (r_state == IDLE && w_any_req) begin
            r_last_grant <= w_pick;
        end
    end
`endif

    assign mem_read_en_o = r_read_en;
    assign mem_addr_o    = r_addr;

    // Valid is forwarded only to the current owner and only while a read is outstanding.
    assign ic_mem_read_valid_o = mem_read_valid_i & (r_state == BUSY) & (r_owner == OWNER_IC);
    assign dc_mem_read_valid_o = mem_read_valid_i & (r_state == BUSY) & (r_owner == OWNER_DC);

    // Both caches see the DRAM line; the valid pulse says which one should take it.
    assign ic_mem_read_data_o = mem_read_data_i;
    assign dc_mem_read_data_o = mem_read_data_i;

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Directed self-checking bench for dram_read_arbiter with a hand-driven DRAM of latency 10.
// Latency: n/a.
// Backpressure: n/a.
module tb_dram_read_arbiter;

    localparam int LS = 128;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic            ic_mem_read_en_i;
    logic [31:0]     ic_mem_addr_i;
    logic            ic_mem_read_valid_o;
    logic [LS-1:0]   ic_mem_read_data_o;
    logic            dc_mem_read_en_i;
    logic [31:0]     dc_mem_addr_i;
    logic            dc_mem_read_valid_o;
    logic [LS-1:0]   dc_mem_read_data_o;
    logic            mem_read_en_o;
    logic [31:0]     mem_addr_o;
    logic            mem_read_valid_i;
    logic [LS-1:0]   mem_read_data_i;

    dram_read_arbiter #(
        .ByteOffsetBits (4),
        .IndexBits      (6),
        .TagBits        (22)
    ) dut (
        .clk_i               (clk_i),
        .rstn_i              (rstn_i),
        .ic_mem_read_en_i    (ic_mem_read_en_i),
        .ic_mem_addr_i       (ic_mem_addr_i),
        .ic_mem_read_valid_o (ic_mem_read_valid_o),
        .ic_mem_read_data_o  (ic_mem_read_data_o),
        .dc_mem_read_en_i    (dc_mem_read_en_i),
        .dc_mem_addr_i       (dc_mem_addr_i),
        .dc_mem_read_valid_o (dc_mem_read_valid_o),
        .dc_mem_read_data_o  (dc_mem_read_data_o),
        .mem_read_en_o       (mem_read_en_o),
        .mem_addr_o          (mem_addr_o),
        .mem_read_valid_i    (mem_read_valid_i),
        .mem_read_data_i     (mem_read_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          ic_en;
        logic [31:0]   ic_addr;
        logic          dc_en;
        logic [31:0]   dc_addr;
        logic          exp_dc;
        logic [31:0]   exp_addr;
        logic [LS-1:0] line;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [LS-1:0] act, input logic [LS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Request already applied; grant edge, 10-cycle DRAM latency, valid pulse, then DONE cycle.
    task automatic serve(input logic exp_dc, input logic [31:0] exp_addr,
                         input logic [LS-1:0] line, input string tag);
        step();
        chk({tag, ".grant_en"}, LS'(mem_read_en_o), LS'(1'b1));
        chk({tag, ".grant_addr"}, LS'(mem_addr_o), LS'(exp_addr));
        repeat (9) step();
        chk({tag, ".busy_en"}, LS'(mem_read_en_o), LS'(1'b1));
        chk({tag, ".busy_addr"}, LS'(mem_addr_o), LS'(exp_addr));
        mem_read_valid_i = 1'b1;
        mem_read_data_i  = line;
        #1;
        chk({tag, ".ic_valid"}, LS'(ic_mem_read_valid_o), LS'(!exp_dc));
        chk({tag, ".dc_valid"}, LS'(dc_mem_read_valid_o), LS'(exp_dc));
        chk({tag, ".data"}, exp_dc ? dc_mem_read_data_o : ic_mem_read_data_o, line);
        step();
        mem_read_valid_i = 1'b0;
        mem_read_data_i  = '0;
        #1;
        chk({tag, ".done_en"}, LS'(mem_read_en_o), LS'(1'b0));
        chk({tag, ".done_valids"}, LS'({ic_mem_read_valid_o, dc_mem_read_valid_o}), LS'(2'b00));
    endtask

    initial begin
        rstn_i           = 1'b0;
        ic_mem_read_en_i = 1'b0;
        ic_mem_addr_i    = '0;
        dc_mem_read_en_i = 1'b0;
        dc_mem_addr_i    = '0;
        mem_read_valid_i = 1'b1;
        mem_read_data_i  = '1;

        // Reset state; a DRAM valid during reset must not be forwarded.
        repeat (2) step();
        chk("reset.en", LS'(mem_read_en_o), LS'(1'b0));
        chk("reset.addr", LS'(mem_addr_o), LS'(32'h0));
        chk("reset.valids", LS'({ic_mem_read_valid_o, dc_mem_read_valid_o}), LS'(2'b00));
        mem_read_valid_i = 1'b0;
        mem_read_data_i  = '0;
        rstn_i = 1'b1;
        step();
        chk("reset.idle_en", LS'(mem_read_en_o), LS'(1'b0));

        // Simultaneous requests right after reset.
        ic_mem_read_en_i = 1'b1; ic_mem_addr_i = 32'h0000_0424;
        dc_mem_read_en_i = 1'b1; dc_mem_addr_i = 32'h0000_0818;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        serve(1'b0, 32'h0000_0420, {4{32'hA5A5_0001}}, "tie.first_ic");
        ic_mem_read_en_i = 1'b0;
        step();
        chk("tie.gap_en", LS'(mem_read_en_o), LS'(1'b0));
        serve(1'b1, 32'h0000_0810, {4{32'hA5A5_0002}}, "tie.second_dc");
        dc_mem_read_en_i = 1'b0;
`else
        serve(1'b1, 32'h0000_0810, {4{32'hA5A5_0002}}, "tie.first_dc");
        dc_mem_read_en_i = 1'b0;
        step();
        chk("tie.gap_en", LS'(mem_read_en_o), LS'(1'b0));
        serve(1'b0, 32'h0000_0420, {4{32'hA5A5_0001}}, "tie.second_ic");
        ic_mem_read_en_i = 1'b0;
`endif
        step();

        // Table: last grant is DC at this point in both builds.
        vecs[0] = '{1'b1, 32'h0000_0414, 1'b0, 32'h0,         1'b0, 32'h0000_0410, {4{32'h1111_0000}}};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_0818, 1'b1, 32'h0000_0810, {4{32'h2222_0000}}};
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        vecs[2] = '{1'b1, 32'h0000_0424, 1'b1, 32'h0000_043C, 1'b0, 32'h0000_0420, {4{32'h3333_0000}}};
`else
        vecs[2] = '{1'b1, 32'h0000_0424, 1'b1, 32'h0000_043C, 1'b1, 32'h0000_0430, {4{32'h3333_0000}}};
`endif
        vecs[3] = '{1'b1, 32'h0000_05FF, 1'b1, 32'h0000_0700, 1'b1, 32'h0000_0700, {4{32'h4444_0000}}};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFF0, {4{32'h5555_0000}}};

        for (int i = 0; i < 5; i++) begin
            ic_mem_read_en_i = vecs[i].ic_en;
            ic_mem_addr_i    = vecs[i].ic_addr;
            dc_mem_read_en_i = vecs[i].dc_en;
            dc_mem_addr_i    = vecs[i].dc_addr;
            serve(vecs[i].exp_dc, vecs[i].exp_addr, vecs[i].line, $sformatf("vec%0d", i));
            ic_mem_read_en_i = 1'b0;
            dc_mem_read_en_i = 1'b0;
            step();
        end

        // IC keeps its request through the DONE cycle: no second read.
        ic_mem_read_en_i = 1'b1; ic_mem_addr_i = 32'h0000_0414;
        serve(1'b0, 32'h0000_0410, {4{32'h6666_0000}}, "hold");
        step();
        chk("hold.idle_en", LS'(mem_read_en_o), LS'(1'b0));
        ic_mem_read_en_i = 1'b0;
        step();
        chk("hold.no_regrant", LS'(mem_read_en_o), LS'(1'b0));
        step();
        chk("hold.still_idle", LS'(mem_read_en_o), LS'(1'b0));

        // Reset 4 cycles into a DC read; the late DRAM valid is dropped.
        dc_mem_read_en_i = 1'b1; dc_mem_addr_i = 32'h0000_0440;
        step();
        chk("rst_busy.grant_addr", LS'(mem_addr_o), LS'(32'h0000_0440));
        repeat (4) step();
        rstn_i = 1'b0;
        #1;
        chk("rst_busy.en", LS'(mem_read_en_o), LS'(1'b0));
        chk("rst_busy.addr", LS'(mem_addr_o), LS'(32'h0));
        dc_mem_read_en_i = 1'b0;
        step();
        rstn_i = 1'b1;
        repeat (4) step();
        mem_read_valid_i = 1'b1;
        mem_read_data_i  = {4{32'hDEAD_BEEF}};
        #1;
        chk("rst_busy.late_valid", LS'({ic_mem_read_valid_o, dc_mem_read_valid_o}), LS'(2'b00));
        chk("rst_busy.late_en", LS'(mem_read_en_o), LS'(1'b0));
        step();
        mem_read_valid_i = 1'b0;
        mem_read_data_i  = '0;
        step();

        // DC arrives while IC is busy; it waits, then is granted right after DONE.
        ic_mem_read_en_i = 1'b1; ic_mem_addr_i = 32'h0000_0414;
        step();
        chk("wait.ic_addr", LS'(mem_addr_o), LS'(32'h0000_0410));
        repeat (3) step();
        dc_mem_read_en_i = 1'b1; dc_mem_addr_i = 32'h0000_088C;
        repeat (6) step();
        chk("wait.addr_held", LS'(mem_addr_o), LS'(32'h0000_0410));
        mem_read_valid_i = 1'b1;
        mem_read_data_i  = {4{32'h7777_0000}};
        #1;
        chk("wait.ic_valid", LS'({ic_mem_read_valid_o, dc_mem_read_valid_o}), LS'(2'b10));
        ic_mem_read_en_i = 1'b0;
        step();
        mem_read_valid_i = 1'b0;
        mem_read_data_i  = '0;
        #1;
        chk("wait.done_en", LS'(mem_read_en_o), LS'(1'b0));
        step();
        chk("wait.idle_en", LS'(mem_read_en_o), LS'(1'b0));
        step();
        chk("wait.dc_en", LS'(mem_read_en_o), LS'(1'b1));
        chk("wait.dc_addr", LS'(mem_addr_o), LS'(32'h0000_0880));
        repeat (9) step();
        mem_read_valid_i = 1'b1;
        mem_read_data_i  = {4{32'h8888_0000}};
        #1;
        chk("wait.dc_valid", LS'({ic_mem_read_valid_o, dc_mem_read_valid_o}), LS'(2'b01));
        chk("wait.dc_data", dc_mem_read_data_o, {4{32'h8888_0000}});
        dc_mem_read_en_i = 1'b0;
        step();
        mem_read_valid_i = 1'b0;
        mem_read_data_i  = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
